// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
//
// Purpose: word width, instruction size, fetch FSM state encoding and the
//          buffered-entry layout used by instr_fetch and fetch_fifo.
// Ports:   none (package).
package fetch_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched instructions with flush
//
// Purpose: synchronous FIFO of fetch_entry_t; flush empties it in one edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             discard every entry (wins over push/pop)
//   push, push_entry  write one entry (ignored when full without a pop)
//   pop               remove the head entry (ignored when empty)
//   head              current head entry (meaningful only when !empty)
//   full, empty       occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves this edge.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch with redirect and halt
//
// Purpose: walks pc through instruction memory, buffers {pc, word} pairs for
//          the decoder, handles redirects and halts on a misaligned target.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   address / data                   instruction memory read (data same cycle)
//   redirect_valid, redirect_target  branch/jump request
//   out_valid, out_ready             decoder handshake
//   out_instr, out_pc                head instruction and its byte address
//   fetch_error                      halted on a misaligned redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] address,
  input  logic [31:0] data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_error
);

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(INSTR_BYTES);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              fetch_error_q, fetch_error_d;

  logic              push, flush, pop;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      push_entry, head;

  assign address     = pc_q;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign out_instr   = out_valid ? head.instr : '0;
  assign out_pc      = out_valid ? head.pc : '0;
  assign fetch_error = fetch_error_q;
  assign push_entry  = '{pc: pc_q, instr: data};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_error_d = fetch_error_q;
    push          = 1'b0;
    flush         = 1'b0;
    if (state_q == RUN) begin
      if (redirect_valid) begin
        // Any pop this edge is already consumed; flush drops what remains.
        flush = 1'b1;
        if (redirect_target[1:0] == 2'b00) begin
          pc_d = redirect_target;
        end else begin
          state_d       = HALT;
          fetch_error_d = 1'b1;
        end
      end else if (!fifo_full || pop) begin
        push = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, out_ready, out_valid, fetch_error;
  logic [31:0] address, data, redirect_target, out_instr, out_pc;

  logic        rst_n2, redirect_valid2, out_ready2, out_valid2, fetch_error2;
  logic [31:0] address2, data2, redirect_target2, out_instr2, out_pc2;

  // Memory model: word i holds 0x13 + i.
  assign data  = 32'h13 + (address >> 2);
  assign data2 = 32'h13 + (address2 >> 2);

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_error(fetch_error)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .address(address2), .data(data2),
    .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc(out_pc2), .fetch_error(fetch_error2)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %08h required %08h", name, got, exp);
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b required %b", name, got, exp);
  endtask

  function automatic logic [63:0] mk_entry(input logic [31:0] pc);
    return {pc, 32'h13 + (pc >> 2)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q1.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected_output: got pc %08h, required no output", out_pc);
      end else begin
        logic [63:0] e;
        e = exp_q1.pop_front();
        check32("dut1_out_pc", out_pc, e[63:32]);
        check32("dut1_out_instr", out_instr, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n2 && out_valid2 && out_ready2) begin
      if (exp_q2.size() == 0) begin
        total_cnt++;
        $display("FAIL dut2_unexpected_output: got pc %08h, required no output", out_pc2);
      end else begin
        logic [63:0] e;
        e = exp_q2.pop_front();
        check32("dut2_out_pc", out_pc2, e[63:32]);
        check32("dut2_out_instr", out_instr2, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;
    rst_n2 = 1'b0; redirect_valid2 = 1'b0; redirect_target2 = '0; out_ready2 = 1'b0;
    tick(2);

    // Reset state
    check1("rst_out_valid", out_valid, 1'b0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_out_instr", out_instr, 32'h0);
    check1("rst_fetch_error", fetch_error, 1'b0);
    check32("rst_address", address, 32'h0);
    check32("rst_address2", address2, 32'hFFFF_FFF8);

    // Streaming with out_ready high from the first edge
    for (int i = 0; i < 4; i++) exp_q1.push_back(mk_entry(32'(i * 4)));
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check1("stream_out_valid", out_valid, 1'b1);
    end
    tick(1);
    out_ready = 1'b0;

    // Back-pressure: two entries held, address frozen, no loss afterwards
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check32("stall_address_e2", address, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check32("stall_address", address, 32'h8);
    end
    check1("stall_out_valid", out_valid, 1'b1);
    check32("stall_head_pc", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) exp_q1.push_back(mk_entry(32'(i * 4)));
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;

    // Redirect to 0x40 together with the pop of pc 8
    rst_n = 1'b0;
    tick(1);
    exp_q1.push_back(mk_entry(32'h0));
    exp_q1.push_back(mk_entry(32'h4));
    exp_q1.push_back(mk_entry(32'h8));
    exp_q1.push_back(mk_entry(32'h40));
    exp_q1.push_back(mk_entry(32'h44));
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick(3);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick(1);
    redirect_valid = 1'b0;
    check1("redir_flushed_valid", out_valid, 1'b0);
    check32("redir_address", address, 32'h40);
    tick(3);
    out_ready = 1'b0;

    // Misaligned redirect halts; later redirect ignored; reset clears
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    tick(1);
    redirect_valid = 1'b0;
    check1("halt_fetch_error", fetch_error, 1'b1);
    check1("halt_out_valid", out_valid, 1'b0);
    check32("halt_address", address, 32'h8);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    check1("halt_ignore_fetch_error", fetch_error, 1'b1);
    check32("halt_ignore_address", address, 32'h8);
    check1("halt_ignore_out_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("halt_reset_fetch_error", fetch_error, 1'b0);
    check32("halt_reset_address", address, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check1("first_push_out_valid", out_valid, 1'b1);
    check32("first_push_out_pc", out_pc, 32'h0);
    check1("after_reset_fetch_error", fetch_error, 1'b0);

    // Asynchronous reset between edges with two entries buffered
    tick(1);
    check32("async_pre_address", address, 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    check1("async_out_valid", out_valid, 1'b0);
    check32("async_address", address, 32'h0);
    check32("async_out_pc", out_pc, 32'h0);
    check32("async_out_instr", out_instr, 32'h0);

    // pc wrap from RESET_PC = FFFF_FFF8
    tick(1);
    exp_q2.push_back(mk_entry(32'hFFFF_FFF8));
    exp_q2.push_back(mk_entry(32'hFFFF_FFFC));
    exp_q2.push_back(mk_entry(32'h0000_0000));
    out_ready2 = 1'b1;
    rst_n2 = 1'b1;
    tick(4);
    out_ready2 = 1'b0;
    tick(2);

    check32("dut1_pending_expected", 32'(exp_q1.size()), 32'h0);
    check32("dut2_pending_expected", 32'(exp_q2.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
